aes_key_expand: RTL and testbench

//   AES-128 key schedule generator (FIPS-197 sec 5.2, Nk=4). Sits upstream of the round datapath:

---
 rtl/aes_key_expand.sv | 99 +++++++++
 tb/tb_aes_key_expand.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128 key schedule that streams round keys 0..NR over a valid/ready handshake
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   start     in   begin expansion of key (only sampled while idle)
//   key       in   128-bit cipher key, w[0]=[127:96] .. w[3]=[31:0]
//   busy      out  expansion in progress
//   rk_valid  out  round_key/round_idx valid
//   rk_ready  in   consumer takes the current round key
//   round_key out  current round key
//   round_idx out  index of round_key, 0..NR
//   rk_last   out  final round key is being presented
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_last
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;
    localparam logic [3:0] LAST = 4'(NR);

    logic [0:0]  state;
    logic [7:0]  rcon;
    logic [31:0] rot, sub, t, w0n, w1n, w2n, w3n;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, b;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        b    = gmul(gmul(x240, x12), x2);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign rot = {round_key[23:0], round_key[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign t   = sub ^ {rcon, 24'h0};
    assign w0n = round_key[127:96] ^ t;
    assign w1n = round_key[95:64] ^ w0n;
    assign w2n = round_key[63:32] ^ w1n;
    assign w3n = round_key[31:0] ^ w2n;

    assign busy     = state == EMIT;
    assign rk_valid = state == EMIT;
    assign rk_last  = rk_valid && round_idx == LAST;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            rcon      <= 8'h01;
        end else if (state == IDLE) begin
            if (start) begin
                state     <= EMIT;
                round_key <= key;
                round_idx <= '0;
                rcon      <= 8'h01;
            end
        end else if (rk_ready) begin
            if (round_idx == LAST) begin
                state <= IDLE;
            end else begin
                round_key <= {w0n, w1n, w2n, w3n};
                round_idx <= round_idx + 4'd1;
                rcon      <= xtime(rcon);
            end
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed self-checking bench for aes_key_expand (NR=10)
module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         reset, start, rk_ready;
    logic [127:0] key;
    logic         busy, rk_valid, rk_last;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] fips [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_key_expand #(.NR(10)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
        .round_idx(round_idx), .rk_last(rk_last)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
        key   = '0;
    endtask

    task automatic drain;
        int n = 0;
        rk_ready = 1'b1;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; rk_ready = 1'b0; key = '0;
        tick();
        tick();
        checks++;
        if ({busy, rk_valid, rk_last, round_idx, round_key} !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b valid=%b last=%b idx=%0d key=%h want all 0",
                     busy, rk_valid, rk_last, round_idx, round_key);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fips_stream;
        rk_ready = 1'b1;
        do_start(KEY_A1);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || round_idx !== 4'(i) || round_key !== fips[i]
                || rk_last !== (i == 10)) begin
                errors++;
                $display("FAIL fips_idx%0d valid=%b busy=%b idx=%0d last=%b key=%h want key=%h",
                         i, rk_valid, busy, round_idx, rk_last, round_key, fips[i]);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0 || round_idx !== 4'd10
            || round_key !== fips[10]) begin
            errors++;
            $display("FAIL fips_done busy=%b valid=%b last=%b idx=%0d key=%h want 0/0/0/10/%h",
                     busy, rk_valid, rk_last, round_idx, round_key, fips[10]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rk_valid !== 1'b0 || round_idx !== 4'd10) begin
                errors++;
                $display("FAIL ready_while_idle valid=%b idx=%0d want 0/10", rk_valid, round_idx);
            end
        end
    endtask

    task automatic test_zero_key;
        rk_ready = 1'b1;
        do_start('0);
        checks++;
        if (round_key !== '0 || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL zero_idx0 key=%h idx=%0d want 0/0", round_key, round_idx);
        end
        tick();
        checks++;
        if (round_key !== 128'h62636363626363636263636362636363 || round_idx !== 4'd1) begin
            errors++;
            $display("FAIL zero_idx1 key=%h idx=%0d want 62636363626363636263636362636363/1",
                     round_key, round_idx);
        end
        drain();
    endtask

    task automatic test_backpressure;
        int hs = 0;
        int stall = 0;
        int cyc = 0;
        logic fire;
        rk_ready = 1'b0;
        do_start(KEY_A1);
        while (busy && cyc < 300) begin
            checks++;
            if (rk_valid !== 1'b1 || round_idx !== 4'(hs) || round_key !== fips[hs]) begin
                errors++;
                $display("FAIL bp_cyc%0d valid=%b idx=%0d key=%h want 1/%0d/%h",
                         cyc, rk_valid, round_idx, round_key, hs, fips[hs]);
            end
            if (hs == 0 && cyc < 2) rk_ready = 1'b0;
            else if (hs == 4 && stall < 5) begin
                rk_ready = 1'b0;
                stall++;
            end else rk_ready = 1'($urandom_range(0, 1));
            fire = rk_ready && rk_valid;
            tick();
            if (fire) hs++;
            cyc++;
        end
        rk_ready = 1'b0;
        checks++;
        if (hs != 11 || busy !== 1'b0 || stall != 5) begin
            errors++;
            $display("FAIL bp_count handshakes=%0d busy=%b stall=%0d want 11/0/5", hs, busy, stall);
        end
        tick();
    endtask

    task automatic test_start_ignored;
        rk_ready = 1'b1;
        do_start(KEY_A1);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (round_idx !== 4'(i) || round_key !== fips[i] || rk_valid !== 1'b1) begin
                errors++;
                $display("FAIL ign_idx%0d idx=%0d key=%h valid=%b want %0d/%h/1",
                         i, round_idx, round_key, rk_valid, i, fips[i]);
            end
            start = (i == 3);
            key   = (i == 3) ? KEY_C1 : '0;
            tick();
        end
        start = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid;
        rk_ready = 1'b1;
        do_start(KEY_A1);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (round_idx !== 4'd6 || round_key !== fips[6]) begin
            errors++;
            $display("FAIL rst_pre idx=%0d key=%h want 6/%h", round_idx, round_key, fips[6]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, rk_valid, rk_last, round_idx, round_key} !== '0) begin
            errors++;
            $display("FAIL rst_mid busy=%b valid=%b last=%b idx=%0d key=%h want all 0",
                     busy, rk_valid, rk_last, round_idx, round_key);
        end
        tick();
        checks++;
        if (rk_valid !== 1'b0 || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL rst_after valid=%b idx=%0d want 0/0", rk_valid, round_idx);
        end
        reset = 1'b1;
        start = 1'b1;
        key   = KEY_C1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || round_key !== '0) begin
            errors++;
            $display("FAIL rst_vs_start valid=%b busy=%b key=%h want 0/0/0", rk_valid, busy, round_key);
        end
        do_start(KEY_C1);
        checks++;
        if (round_key !== KEY_C1 || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL c1_idx0 key=%h idx=%0d want %h/0", round_key, round_idx, KEY_C1);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (round_key !== 128'h13111d7fe3944a17f307a78b4d2b30c5 || round_idx !== 4'd10
            || rk_last !== 1'b1) begin
            errors++;
            $display("FAIL c1_idx10 key=%h idx=%0d last=%b want 13111d7fe3944a17f307a78b4d2b30c5/10/1",
                     round_key, round_idx, rk_last);
        end
        drain();
    endtask

    task automatic test_start_at_final;
        rk_ready = 1'b1;
        do_start(KEY_A1);
        for (int i = 0; i < 10; i++) tick();
        start = 1'b1;
        key   = KEY_C1;
        tick();
        start = 1'b0;
        key   = '0;
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || round_key !== fips[10]) begin
            errors++;
            $display("FAIL final_start busy=%b valid=%b key=%h want 0/0/%h",
                     busy, rk_valid, round_key, fips[10]);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL final_start_late busy=%b valid=%b want 0/0", busy, rk_valid);
        end
        do_start(KEY_C1);
        checks++;
        if (busy !== 1'b1 || rk_valid !== 1'b1 || round_key !== KEY_C1 || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL restart busy=%b valid=%b key=%h idx=%0d want 1/1/%h/0",
                     busy, rk_valid, round_key, round_idx, KEY_C1);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fips_stream();
        test_zero_key();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_start_at_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
